// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM states, error codes and funct3 size encodings for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} lsu_state_e;
  localparam logic [1:0] LSU_ERR_NONE     = 2'b00;
  localparam logic [1:0] LSU_ERR_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] LSU_ERR_ILLEGAL  = 2'b11;
  localparam logic [2:0] LSU_SZ_B  = 3'b000;
  localparam logic [2:0] LSU_SZ_H  = 3'b001;
  localparam logic [2:0] LSU_SZ_W  = 3'b010;
  localparam logic [2:0] LSU_SZ_BU = 3'b100;
  localparam logic [2:0] LSU_SZ_HU = 3'b101;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: extracts the addressed byte/half from a bus word and sign- or zero-extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);
  logic [31:0] b_sh, h_sh;
  logic        sgn;
  assign b_sh = rdata >> {lo, 3'b000};
  assign h_sh = rdata >> {lo[1], 4'b0000};
  assign sgn  = ~size[2];
  always_comb
    result = (size[1:0] == LSU_SZ_B[1:0]) ? {{24{b_sh[7] & sgn}}, b_sh[7:0]} :
             (size[1:0] == LSU_SZ_H[1:0]) ? {{16{h_sh[15] & sgn}}, h_sh[15:0]} : rdata;
endmodule

// File: rtl/lsu_mem.sv
// lsu_mem: MEM-stage load/store unit; define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them
module lsu_mem
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              mem_we_i,
  input  logic              mem_re_i,
  input  logic [2:0]        mem_size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [1:0]        err_code_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_wstrb_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  lsu_state_e  state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]  size_q;
  logic [1:0]  lo_q, lo;
  logic        we_q, accept, illegal, mis, err_now, timeout, is_b, is_h, is_w;
  logic [3:0]  wstrb;
  logic [31:0] wdata, load_res;
  assign is_b    = mem_size_i[1:0] == LSU_SZ_B[1:0];
  assign is_h    = mem_size_i[1:0] == LSU_SZ_H[1:0];
  assign is_w    = mem_size_i[1:0] == LSU_SZ_W[1:0];
  assign accept  = state == IDLE && req_valid_i && (mem_we_i || mem_re_i);
  assign illegal = mem_we_i ? mem_size_i > LSU_SZ_W : (mem_size_i == 3'b011 || mem_size_i[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (is_h && addr_i[0]) || (is_w && addr_i[1:0] != 2'b00);
  assign lo  = addr_i[1:0];
`else
  assign mis = 1'b0;
  assign lo  = is_w ? 2'b00 : is_h ? {addr_i[1], 1'b0} : addr_i[1:0];
`endif
  assign err_now = illegal || mis;
  assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign done_o  = state == DONE;
  assign wstrb   = !mem_we_i ? 4'b0000 : is_b ? 4'b0001 << lo : is_h ? 4'b0011 << {lo[1], 1'b0} : 4'b1111;
  assign wdata   = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
  lsu_load_align u_align (.size(size_q), .lo(lo_q), .rdata(bus_rdata_i), .result(load_res));
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    case (state)
      IDLE: begin
        stall_o = accept;
        if (accept) state_n = err_now ? DONE : REQ;
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus_gnt_i) state_n = we_q ? DONE : WAIT_RESP;
        else if (timeout) state_n = DONE;
      end
      WAIT_RESP: begin
        stall_o = 1'b1;
        if (bus_rvalid_i || timeout) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // Grant/response win over a timeout landing in the same cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wstrb_o <= '0;
      bus_wdata_o <= '0;
      rdata_o     <= '0;
      err_o       <= 1'b0;
      err_code_o  <= LSU_ERR_NONE;
      size_q      <= '0;
      lo_q        <= '0;
      we_q        <= 1'b0;
      cnt         <= '0;
    end else if (accept) begin
      bus_req_o   <= !err_now;
      bus_we_o    <= mem_we_i;
      bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
      bus_wstrb_o <= wstrb;
      bus_wdata_o <= wdata;
      size_q      <= mem_size_i;
      lo_q        <= lo;
      we_q        <= mem_we_i;
      cnt         <= '0;
      if (err_now) begin
        err_o      <= 1'b1;
        err_code_o <= illegal ? LSU_ERR_ILLEGAL : LSU_ERR_MISALIGN;
        rdata_o    <= '0;
      end
    end else if (state == REQ || state == WAIT_RESP) begin
      cnt <= cnt + 1'b1;
      if (state == REQ && bus_gnt_i) begin
        bus_req_o <= 1'b0;
        if (we_q) begin
          err_o      <= 1'b0;
          err_code_o <= LSU_ERR_NONE;
        end
      end else if (state == WAIT_RESP && bus_rvalid_i) begin
        rdata_o    <= load_res;
        err_o      <= 1'b0;
        err_code_o <= LSU_ERR_NONE;
      end else if (timeout) begin
        bus_req_o  <= 1'b0;
        err_o      <= 1'b1;
        err_code_o <= LSU_ERR_TIMEOUT;
        rdata_o    <= '0;
      end
    end
endmodule

// File: tb/tb_lsu_mem.sv
// tb_lsu_mem: directed self-checking bench for lsu_mem
module tb_lsu_mem;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, mem_we = 1'b0, mem_re = 1'b0;
  logic [2:0]  mem_size = '0;
  logic [31:0] addr = '0, wdata = '0;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        stall, done, err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [1:0]  err_code;
  logic [3:0]  bus_wstrb;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  lsu_mem dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .mem_we_i(mem_we), .mem_re_i(mem_re),
    .mem_size_i(mem_size), .addr_i(addr), .wdata_i(wdata), .stall_o(stall), .done_o(done),
    .rdata_o(rdata), .err_o(err), .err_code_o(err_code), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_wstrb_o(bus_wstrb), .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt),
    .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic issue(input logic we, input logic re, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1; mem_we = we; mem_re = re; mem_size = sz; addr = a; wdata = d;
  endtask
  // Load with grant at +1 and rvalid at +2; done expected at +3.
  task automatic load(input string tag, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b0, 1'b1, sz, a, 32'h0);
    bus_gnt = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd;
    chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_strb"}, 32'(bus_wstrb), 32'h0);
    chk1({tag, "_req"}, bus_req, 1'b1);
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1({tag, "_req_drop"}, bus_req, 1'b0);
    chk1({tag, "_nodone"}, done, 1'b0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk1({tag, "_done"}, done, 1'b1);
    chk({tag, "_rdata"}, rdata, exp);
    chk1({tag, "_err"}, err, 1'b0);
    @(negedge clk);
    chk1({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_hold"}, rdata, exp);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk1("rst_done", done, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_req", bus_req, 1'b0);
    chk("rst_code", 32'(err_code), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'hDEADBEEF);
    bus_gnt = 1'b1;
    #1 chk1("sw_stall_accept", stall, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk1("sw_req", bus_req, 1'b1);
    chk1("sw_we", bus_we, 1'b1);
    chk("sw_addr", bus_addr, 32'h100);
    chk("sw_strb", 32'(bus_wstrb), 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEADBEEF);
    chk1("sw_nodone", done, 1'b0);
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1("sw_done", done, 1'b1);
    chk1("sw_err", err, 1'b0);
    chk1("sw_stall_done", stall, 1'b0);
    @(negedge clk);
    chk1("sw_done_clr", done, 1'b0);
    issue(1'b1, 1'b0, 3'b000, 32'h203, 32'h5A);
    @(negedge clk);
    req_valid = 1'b0;
    chk("sb_addr", bus_addr, 32'h200);
    chk("sb_strb", 32'(bus_wstrb), 32'h8);
    chk("sb_wdata", bus_wdata, 32'h5A5A5A5A);
    @(negedge clk);
    chk1("sb_req_held", bus_req, 1'b1);
    chk1("sb_stall_held", stall, 1'b1);
    chk("sb_addr_held", bus_addr, 32'h200);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1("sb_done", done, 1'b1);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b001, 32'h012, 32'hCAFE);
    bus_gnt = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("sh_strb", 32'(bus_wstrb), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hCAFECAFE);
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1("sh_done", done, 1'b1);
    @(negedge clk);
    issue(1'b1, 1'b1, 3'b010, 32'h10, 32'h11223344);
    bus_gnt = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk1("both_we", bus_we, 1'b1);
    chk("both_strb", 32'(bus_wstrb), 32'hF);
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1("both_done", done, 1'b1);
    @(negedge clk);
    issue(1'b1, 1'b0, 3'b011, 32'h20, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk1("ill_st_done", done, 1'b1);
    chk1("ill_st_req", bus_req, 1'b0);
    chk1("ill_st_err", err, 1'b1);
    chk("ill_st_code", 32'(err_code), 32'h3);
    @(negedge clk);
    issue(1'b0, 1'b1, 3'b110, 32'h20, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk1("ill_ld_done", done, 1'b1);
    chk("ill_ld_code", 32'(err_code), 32'h3);
    @(negedge clk);
    issue(1'b0, 1'b1, 3'b010, 32'h400, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (15) @(negedge clk);
    chk1("to_stall_pre", stall, 1'b1);
    chk1("to_req_pre", bus_req, 1'b1);
    chk1("to_nodone_pre", done, 1'b0);
    @(negedge clk);
    chk1("to_done", done, 1'b1);
    chk1("to_err", err, 1'b1);
    chk("to_code", 32'(err_code), 32'h2);
    chk("to_rdata", rdata, 32'h0);
    chk1("to_req_drop", bus_req, 1'b0);
    chk1("to_stall_rel", stall, 1'b0);
    @(negedge clk);
    chk("to_code_hold", 32'(err_code), 32'h2);
    load("lb", 3'b000, 32'h302, 32'h0080FF11, 32'hFFFFFF80);
    load("lbu", 3'b100, 32'h302, 32'h0080FF11, 32'h00000080);
    load("lh", 3'b001, 32'h302, 32'h0080FF11, 32'h00000080);
    load("lh_neg", 3'b001, 32'h302, 32'h80001234, 32'hFFFF8000);
    load("lhu", 3'b101, 32'h302, 32'h80001234, 32'h00008000);
    load("lw", 3'b010, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 1'b1, 3'b001, 32'h101, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk1("mis_done", done, 1'b1);
    chk1("mis_req", bus_req, 1'b0);
    chk1("mis_err", err, 1'b1);
    chk("mis_code", 32'(err_code), 32'h1);
    @(negedge clk);
    load("lb_after", 3'b000, 32'h301, 32'h0000A500, 32'hFFFFFFA5);
`else
    load("lh_mis", 3'b001, 32'h101, 32'h1234ABCD, 32'hFFFFABCD);
`endif
    issue(1'b0, 1'b1, 3'b010, 32'h500, 32'h0);
    bus_gnt = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk1("rw_stall_wait", stall, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rw_stall", stall, 1'b0);
    chk1("rw_done", done, 1'b0);
    chk1("rw_req", bus_req, 1'b0);
    chk("rw_rdata", rdata, 32'h0);
    chk("rw_addr", bus_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("rw_no_done", done, 1'b0);
      chk1("rw_idle_stall", stall, 1'b0);
    end
    bus_rvalid = 1'b0;
    chk("rw_rdata_after", rdata, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_mem.md
Name: lsu_mem

Overview:
Load/store unit that services the memory requests produced by the decode stage: mem_re/mem_we, mem_size (funct3 encoding), address and store data.
- Sits in the MEM stage, between the EX/MEM pipeline register and the data-memory bus.
- Converts each request into a single word-aligned bus transaction with byte strobes.
- Returns sign- or zero-extended load data to writeback and stalls the pipeline until the access completes.

Parameters:
TIMEOUT_CYCLES, 16, max cycles spent in REQ+WAIT_RESP before aborting with a timeout error (>=2).
ADDR_W, 32, byte-address width.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
req_valid_i  in  1  request present from EX/MEM
mem_we_i  in  1  store request
mem_re_i  in  1  load request
mem_size_i  in  3  funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
addr_i  in  ADDR_W  effective byte address
wdata_i  in  32  store data, right-aligned
stall_o  out  1  hold upstream pipeline
done_o  out  1  one-cycle completion pulse
rdata_o  out  32  extended load data, valid with done_o
err_o  out  1  access failed, valid with done_o
err_code_o  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal size
bus_req_o  out  1  bus request
bus_we_o  out  1  bus write
bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
bus_wstrb_o  out  4  byte strobes
bus_wdata_o  out  32  lane-replicated store data
bus_gnt_i  in  1  request accepted this cycle
bus_rvalid_i  in  1  read data valid
bus_rdata_i  in  32  read word

Behaviour:
Reset, asynchronous:
- FSM goes to IDLE.
- All outputs go to 0; the timeout counter clears.

FSM states: IDLE, REQ, WAIT_RESP, DONE.

IDLE:
- Accept when req_valid_i && (mem_we_i || mem_re_i). If both are set, treat as a store.
- On accept: register the bus outputs, latch size/addr[1:0]/we, clear the counter, go to REQ.
- stall_o = accept, combinational, so the pipeline holds in the accept cycle.

Illegal size in IDLE:
- Illegal loads: 011, 110, 111. Illegal stores: >=011.
- Go to DONE without a bus access, err_code 11.

REQ:
- bus_req_o = 1; address, strobes and data are held stable until bus_gnt_i.
- On grant, a store goes to DONE (posted write).
- On grant, a load goes to WAIT_RESP and bus_req_o drops.

WAIT_RESP:
- bus_rvalid_i is sampled only in this state.
- On rvalid: capture the extended data into rdata_o and go to DONE.

DONE:
- done_o = 1 for exactly one cycle; stall_o = 0; then go to IDLE.
- A new request cannot be accepted in DONE. Upstream advances on the done cycle and presents the next request in IDLE.

stall_o is 1 in REQ and WAIT_RESP.

Timeout:
- The counter increments in REQ/WAIT_RESP.
- When the count reaches TIMEOUT_CYCLES-1: go to DONE with err_o=1, err_code 10, rdata_o=0, and drop bus_req_o.

Strobes and data:
- SB: wstrb = 0001<<addr[1:0], data = {4{wdata[7:0]}}.
- SH: wstrb = 0011<<{addr[1],1'b0}, data = {2{wdata[15:0]}}.
- SW: wstrb = 1111.
- Loads: wstrb = 0000.

Load extraction:
- Byte = rdata >> (addr[1:0]*8); half = rdata >> (addr[1]*16).
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.

Latency:
- Store with immediate grant: done 2 cycles after accept.
- Load with grant at +1 and rvalid at +2: done at +3.

Edge cases:
- Stray bus_rvalid_i in IDLE/REQ is ignored.
- Reset mid-transaction abandons the access; no done_o is produced.
- rdata_o and err_code_o hold their values until the next done.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, issues no bus access. The FSM goes IDLE->DONE with err_o=1 and err_code 01.
- Undefined: low bits are forced aligned (halfword clears addr[0], word clears addr[1:0]) before strobe and extract computation. The access proceeds normally; 01 is never reported.

Decomposition:
- Package lsu_pkg holds:
  - lsu_state_e enum;
  - LSU_ERR_NONE/MISALIGN/TIMEOUT/ILLEGAL constants;
  - LSU_SZ_B/H/W/BU/HU constants matching the funct3 values.
- Sub-module lsu_load_align: combinational extract and extend (size, addr[1:0], rdata -> 32-bit result), reusable by the write-back path.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt at +1 -> bus_addr=0x100, wstrb=1111, done at +2, err=0.
- SB addr=0x203, wdata=0x5A -> bus_addr=0x200, wstrb=1000, wdata=0x5A5A5A5A.
- LB addr=0x302, bus_rdata=0x0080FF11 -> rdata_o=0xFFFFFF80. LBU, same inputs -> 0x00000080. LH addr=0x302 -> 0x00000080.
- LW with gnt withheld for TIMEOUT_CYCLES -> done with err=1, code 10, bus_req dropped, stall released.
- LH addr=0x101 -> with macro: no bus_req, done at +1, code 01. Without macro: bus_addr=0x100, lower half extracted.
- Assert rst while in WAIT_RESP, then pulse rvalid -> outputs 0, FSM in IDLE, no done_o.
